// File: rtl/crossbar_ctl.sv
// crossbar_ctl: ownership sequencer for the shared-bus crossbar; drives set_owner/clr_owner around each tenure.
// Define CROSSBAR_WATCHDOG_EN to build the idle watchdog that forces release and sets timeout_err.
module crossbar_ctl #(
   parameter  int MAX_OUTSTANDING = 4,
   parameter  int MAX_GRANT_BEATS = 8,
   parameter  int TIMEOUT_CYCLES  = 1024,
   localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [15:0]      request,
   input  logic [15:0]      grant,
   input  logic             a_fire,
   input  logic             d_fire,
   output logic             set_owner,
   output logic             clr_owner,
   output logic             busy,
   output logic [OUT_W-1:0] outstanding,
   output logic             ovf_err,
   output logic             timeout_err
);

   localparam int                BEAT_W   = $clog2(MAX_GRANT_BEATS + 1);
   localparam logic [OUT_W-1:0]  OUT_MAX  = OUT_W'(MAX_OUTSTANDING);
   localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_GRANT_BEATS);

   if (MAX_OUTSTANDING < 1 || MAX_GRANT_BEATS < 1 || TIMEOUT_CYCLES < 2) begin : g_param_chk
      $error("crossbar_ctl: parameter out of range");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_OWN,
      S_DRAIN,
      S_RELEASE
   } state_t;

   state_t            state_q, state_d;
   logic [OUT_W-1:0]  outstanding_q, outstanding_d;
   logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d, beat_inc;
   logic              set_owner_q, clr_owner_q, busy_q;
   logic              ovf_err_q, ovf_err_d;
   logic              in_tenure, quota_hit, wdog_expire;

   assign in_tenure = (state_q == S_OWN) || (state_q == S_DRAIN);

   // Beat count including this cycle's a_fire, saturating so it never wraps.
   assign beat_inc  = (a_fire && (beat_cnt_q != BEAT_MAX)) ? beat_cnt_q + BEAT_W'(1) : beat_cnt_q;
   assign quota_hit = (beat_inc == BEAT_MAX);

`ifdef CROSSBAR_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wdog_q, wdog_d;
   logic            timeout_err_q;

   always_comb begin
      wdog_d      = '0;
      wdog_expire = 1'b0;
      if (in_tenure && !(a_fire || d_fire)) begin
         wdog_d      = wdog_q + WD_W'(1);
         wdog_expire = (wdog_d == WD_W'(TIMEOUT_CYCLES));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_q        <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         wdog_q        <= wdog_d;
         timeout_err_q <= timeout_err_q | wdog_expire;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign wdog_expire = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (|request) state_d = S_GRANT;
         S_GRANT:   state_d = S_OWN;
         S_OWN: begin
            if (wdog_expire || (grant == '0)) state_d = S_RELEASE;
            else if (((request & grant) == '0) || quota_hit) state_d = S_DRAIN;
         end
         S_DRAIN:   if (wdog_expire || (outstanding_q == '0)) state_d = S_RELEASE;
         S_RELEASE: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      outstanding_d = outstanding_q;
      if (in_tenure) begin
         if (a_fire && !d_fire) begin
            if (outstanding_q != OUT_MAX) outstanding_d = outstanding_q + OUT_W'(1);
         end else if (d_fire && !a_fire) begin
            if (outstanding_q != '0) outstanding_d = outstanding_q - OUT_W'(1);
         end else if (a_fire && d_fire && (outstanding_q == '0)) begin
            // A response at zero has nothing to retire, so only the request counts.
            outstanding_d = OUT_W'(1);
         end
      end
      if (state_d == S_RELEASE) outstanding_d = '0;
   end

   always_comb begin
      beat_cnt_d = beat_cnt_q;
      if (state_q == S_GRANT)     beat_cnt_d = '0;
      else if (state_q == S_OWN)  beat_cnt_d = beat_inc;
   end

   assign ovf_err_d = ovf_err_q | (in_tenure && a_fire && (outstanding_q == OUT_MAX));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         set_owner_q   <= 1'b0;
         clr_owner_q   <= 1'b0;
         busy_q        <= 1'b0;
         outstanding_q <= '0;
         beat_cnt_q    <= '0;
         ovf_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         set_owner_q   <= (state_d == S_GRANT);
         clr_owner_q   <= (state_d == S_RELEASE);
         busy_q        <= (state_d != S_IDLE);
         outstanding_q <= outstanding_d;
         beat_cnt_q    <= beat_cnt_d;
         ovf_err_q     <= ovf_err_d;
      end
   end

   assign set_owner   = set_owner_q;
   assign clr_owner   = clr_owner_q;
   assign busy        = busy_q;
   assign outstanding = outstanding_q;
   assign ovf_err     = ovf_err_q;

endmodule

// File: tb/tb_crossbar_ctl.sv
// Directed bench for crossbar_ctl: tenures, drain, beat quota, saturation, async reset, watchdog/no-watchdog, empty grant.
module tb_crossbar_ctl;

   localparam int OUT_W = $clog2(4 + 1);

   logic             clk = 1'b0;
   logic             rst_n;
   logic [15:0]      request;
   logic [15:0]      grant;
   logic             a_fire;
   logic             d_fire;
   logic             set_owner;
   logic             clr_owner;
   logic             busy;
   logic [OUT_W-1:0] outstanding;
   logic             ovf_err;
   logic             timeout_err;

   int checks = 0;
   int errors = 0;

   crossbar_ctl #(
      .MAX_OUTSTANDING(4),
      .MAX_GRANT_BEATS(8),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .request    (request),
      .grant      (grant),
      .a_fire     (a_fire),
      .d_fire     (d_fire),
      .set_owner  (set_owner),
      .clr_owner  (clr_owner),
      .busy       (busy),
      .outstanding(outstanding),
      .ovf_err    (ovf_err),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_set"}, set_owner, 0);
      chk({tag, "_clr"}, clr_owner, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_out"}, outstanding, 0);
      chk({tag, "_ovf"}, ovf_err, 0);
      chk({tag, "_tmo"}, timeout_err, 0);
   endtask

   initial begin
      rst_n = 1'b0; request = '0; grant = '0; a_fire = 1'b0; d_fire = 1'b0;
      tick; tick;
      chk_reset_vals("rst");
      rst_n = 1'b1;
      tick;
      chk("idle_busy", busy, 0);

      // Tenure 1: request held, 3 beats, drop request, 3 responses.
      request = 16'h0004;
      tick; chk("c1_set", set_owner, 1); chk("c1_busy", busy, 1);
      tick; chk("c2_set", set_owner, 0); chk("c2_busy", busy, 1);
      grant = 16'h0004; a_fire = 1'b1;
      tick; chk("c3_out", outstanding, 1);
      tick; chk("c4_out", outstanding, 2);
      tick; chk("c5_out", outstanding, 3);
      a_fire = 1'b0; request = '0;
      tick; chk("c6_out", outstanding, 3); chk("c6_clr", clr_owner, 0); chk("c6_busy", busy, 1);
      d_fire = 1'b1;
      tick; chk("c7_out", outstanding, 2);
      tick; chk("c8_out", outstanding, 1);
      tick; chk("c9_out", outstanding, 0); chk("c9_clr", clr_owner, 0);
      d_fire = 1'b0;
      tick; chk("c10_clr", clr_owner, 1); chk("c10_set", set_owner, 0); chk("c10_busy", busy, 1);
      grant = '0;
      tick; chk("c11_clr", clr_owner, 0); chk("c11_busy", busy, 0);

      // Tenure 2: beat quota with request held; a/d together hold outstanding at 2.
      request = 16'h0010;
      tick; chk("q_set", set_owner, 1);
      tick; grant = 16'h0010; a_fire = 1'b1;
      tick; chk("q_o1_out", outstanding, 1);
      tick; chk("q_o2_out", outstanding, 2);
      d_fire = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick; chk("q_same_out", outstanding, 2);
      end
      tick; chk("q_d0_out", outstanding, 2); chk("q_d0_busy", busy, 1); chk("q_d0_clr", clr_owner, 0);
      a_fire = 1'b0;
      tick; chk("q_d1_out", outstanding, 1);
      tick; chk("q_d2_out", outstanding, 0); chk("q_d2_clr", clr_owner, 0);
      d_fire = 1'b0;
      tick; chk("q_d3_clr", clr_owner, 1);
      grant = '0;
      tick; chk("q_d4_clr", clr_owner, 0); chk("q_d4_set", set_owner, 0); chk("q_d4_busy", busy, 0);
      tick; chk("q_d5_set", set_owner, 1); chk("q_d5_busy", busy, 1);

      // Tenure 3: saturation at 4 sets ovf_err, then async reset mid-tenure.
      tick; grant = 16'h0010; a_fire = 1'b1;
      tick; chk("s_e1_out", outstanding, 1);
      tick; chk("s_e2_out", outstanding, 2);
      tick; chk("s_e3_out", outstanding, 3);
      tick; chk("s_e4_out", outstanding, 4); chk("s_e4_ovf", ovf_err, 0);
      tick; chk("s_e5_out", outstanding, 4); chk("s_e5_ovf", ovf_err, 1);
      a_fire = 1'b0; d_fire = 1'b1;
      tick; chk("s_e6_out", outstanding, 3); chk("s_e6_ovf", ovf_err, 1); chk("s_e6_busy", busy, 1);
      d_fire = 1'b0; request = '0; grant = '0;
      rst_n = 1'b0;
      #2;
      chk_reset_vals("arst");
      tick;
      rst_n = 1'b1;
      tick;

      // Tenure 4: one beat outstanding, no response ever arrives.
      request = 16'h0020;
      tick; chk("w_set", set_owner, 1);
      tick; grant = 16'h0020; a_fire = 1'b1;
      tick; chk("w_out", outstanding, 1);
      a_fire = 1'b0; request = '0;
      tick; chk("w_drain_busy", busy, 1);
      for (int i = 0; i < 40; i++) begin
         tick;
         if (clr_owner === 1'b1) break;
      end
`ifdef CROSSBAR_WATCHDOG_EN
      chk("w_clr", clr_owner, 1);
      chk("w_tmo", timeout_err, 1);
      chk("w_out0", outstanding, 0);
      grant = '0;
      tick; chk("w_idle_busy", busy, 0); chk("w_tmo_sticky", timeout_err, 1);
`else
      chk("w_noclr", clr_owner, 0);
      chk("w_stuck_busy", busy, 1);
      chk("w_stuck_out", outstanding, 1);
      chk("w_tmo0", timeout_err, 0);
`endif
      rst_n = 1'b0; grant = '0;
      tick;
      rst_n = 1'b1;
      tick;

      // Tenure 5: arbiter grants nobody, so OWN releases immediately.
      request = 16'h0040;
      tick; chk("g_set", set_owner, 1);
      tick; chk("g_own_set", set_owner, 0); chk("g_own_clr", clr_owner, 0); chk("g_own_busy", busy, 1);
      tick; chk("g_clr", clr_owner, 1); chk("g_out", outstanding, 0);
      request = '0;
      tick; chk("g_idle_clr", clr_owner, 0); chk("g_idle_busy", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
